// File: rtl/yutorina_pkg.sv
// rtl/yutorina_pkg.sv - shared GPR/word types and constants for the operand stage
package yutorina_pkg;

   localparam int GPR_NUM    = 32;
   localparam int GPR_ADDR_W = $clog2(GPR_NUM);

   typedef logic [31:0]           WordDataBus;
   typedef logic [GPR_ADDR_W-1:0] GprAddrBus;

   localparam GprAddrBus GPR_ZERO = 5'd0;

endpackage

// File: rtl/yutorina_fwd_mux.sv
// rtl/yutorina_fwd_mux.sv - single-operand bypass select, EX > MEM > WB > GPR
module yutorina_fwd_mux
   import yutorina_pkg::*;
#(
   parameter int DATA_W = $bits(WordDataBus),
   parameter int ADDR_W = $bits(GprAddrBus)
) (
   input  logic              i_use,
   input  logic [ADDR_W-1:0] i_rs,
   input  logic [DATA_W-1:0] i_gpr_data,
   input  logic [ADDR_W-1:0] i_ex_rd,
   input  logic              i_ex_we,
   input  logic              i_ex_is_load,
   input  logic [DATA_W-1:0] i_ex_result,
   input  logic [ADDR_W-1:0] i_mem_rd,
   input  logic              i_mem_we,
   input  logic [DATA_W-1:0] i_mem_result,
   input  logic [ADDR_W-1:0] i_wb_rd,
   input  logic              i_wb_we,
   input  logic [DATA_W-1:0] i_wb_data,
   output logic [DATA_W-1:0] o_operand,
   output logic              o_ex_hit
);

   logic w_is_zero;
   logic w_ex_hit;
   logic w_mem_hit;
   logic w_wb_hit;

   assign w_is_zero = (i_rs == ADDR_W'(GPR_ZERO));
   assign w_ex_hit  = i_use && i_ex_we  && (i_ex_rd  == i_rs) && !w_is_zero;
   assign w_mem_hit = i_use && i_mem_we && (i_mem_rd == i_rs) && !w_is_zero;
   assign w_wb_hit  = i_use && i_wb_we  && (i_wb_rd  == i_rs) && !w_is_zero;

   // A load in EX has no data yet; the top stalls, so EX is skipped here.
   always_comb begin
      o_operand = i_gpr_data;
      if (w_is_zero) begin
         o_operand = '0;
      end else if (w_ex_hit && !i_ex_is_load) begin
         o_operand = i_ex_result;
      end else if (w_mem_hit) begin
         o_operand = i_mem_result;
      end else if (w_wb_hit) begin
         o_operand = i_wb_data;
      end
   end

   assign o_ex_hit = w_ex_hit;

endmodule

// File: rtl/yutorina_operand_stage.sv
// rtl/yutorina_operand_stage.sv - operand fetch with forwarding, load-use stall and ID/EX register
module yutorina_operand_stage
   import yutorina_pkg::*;
#(
   parameter int DATA_W = $bits(WordDataBus),
   parameter int ADDR_W = $bits(GprAddrBus)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs0,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic              in_use0,
   input  logic              in_use1,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic              in_rd_we,
   input  logic              in_is_load,
   output logic [ADDR_W-1:0] gpr_addr0,
   output logic [ADDR_W-1:0] gpr_addr1,
   input  logic [DATA_W-1:0] gpr_data0,
   input  logic [DATA_W-1:0] gpr_data1,
   input  logic [ADDR_W-1:0] ex_rd,
   input  logic              ex_we,
   input  logic              ex_is_load,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic              mem_we,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic              wb_we,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_op0,
   output logic [DATA_W-1:0] out_op1,
   output logic [ADDR_W-1:0] out_rd,
   output logic              out_rd_we,
   output logic              out_is_load
);

   logic [DATA_W-1:0] w_op0;
   logic [DATA_W-1:0] w_op1;
   logic              w_ex_hit0;
   logic              w_ex_hit1;
   logic              w_hazard;
   logic              w_adv;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_op0;
   logic [DATA_W-1:0] r_out_op1;
   logic [ADDR_W-1:0] r_out_rd;
   logic              r_out_rd_we;
   logic              r_out_is_load;

   assign gpr_addr0 = in_rs0;
   assign gpr_addr1 = in_rs1;

   yutorina_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd0 (
      .i_use        (in_use0),
      .i_rs         (in_rs0),
      .i_gpr_data   (gpr_data0),
      .i_ex_rd      (ex_rd),
      .i_ex_we      (ex_we),
      .i_ex_is_load (ex_is_load),
      .i_ex_result  (ex_result),
      .i_mem_rd     (mem_rd),
      .i_mem_we     (mem_we),
      .i_mem_result (mem_result),
      .i_wb_rd      (wb_rd),
      .i_wb_we      (wb_we),
      .i_wb_data    (wb_data),
      .o_operand    (w_op0),
      .o_ex_hit     (w_ex_hit0)
   );

   yutorina_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
      .i_use        (in_use1),
      .i_rs         (in_rs1),
      .i_gpr_data   (gpr_data1),
      .i_ex_rd      (ex_rd),
      .i_ex_we      (ex_we),
      .i_ex_is_load (ex_is_load),
      .i_ex_result  (ex_result),
      .i_mem_rd     (mem_rd),
      .i_mem_we     (mem_we),
      .i_mem_result (mem_result),
      .i_wb_rd      (wb_rd),
      .i_wb_we      (wb_we),
      .i_wb_data    (wb_data),
      .o_operand    (w_op1),
      .o_ex_hit     (w_ex_hit1)
   );

   // Load data only exists once the load reaches MEM, so a consumer waits one cycle.
   assign w_hazard = in_valid && ex_is_load && (w_ex_hit0 || w_ex_hit1);
   assign w_adv    = !r_out_valid || out_ready;
   assign in_ready = w_adv && !w_hazard && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid   <= 1'b0;
         r_out_op0     <= '0;
         r_out_op1     <= '0;
         r_out_rd      <= '0;
         r_out_rd_we   <= 1'b0;
         r_out_is_load <= 1'b0;
      end else if (flush) begin
         r_out_valid   <= 1'b0;
      end else if (w_adv) begin
         r_out_valid   <= in_valid && !w_hazard;
         r_out_op0     <= w_op0;
         r_out_op1     <= w_op1;
         r_out_rd      <= in_rd;
         r_out_rd_we   <= in_rd_we;
         r_out_is_load <= in_is_load;
      end
   end

   assign out_valid   = r_out_valid;
   assign out_op0     = r_out_op0;
   assign out_op1     = r_out_op1;
   assign out_rd      = r_out_rd;
   assign out_rd_we   = r_out_rd_we;
   assign out_is_load = r_out_is_load;

endmodule

// File: tb/tb_yutorina_operand_stage.sv
// tb/tb_yutorina_operand_stage.sv - randomized and directed bench for yutorina_operand_stage
module tb_yutorina_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs0, in_rs1, in_rd;
   logic        in_use0, in_use1, in_rd_we, in_is_load;
   logic [4:0]  gpr_addr0, gpr_addr1;
   logic [31:0] gpr_data0, gpr_data1;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic        ex_we, ex_is_load, mem_we, wb_we;
   logic [31:0] ex_result, mem_result, wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_op0, out_op1;
   logic [4:0]  out_rd;
   logic        out_rd_we, out_is_load;

   always #5 clk = ~clk;

   yutorina_operand_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs0(in_rs0), .in_rs1(in_rs1), .in_use0(in_use0), .in_use1(in_use1),
      .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
      .gpr_addr0(gpr_addr0), .gpr_addr1(gpr_addr1),
      .gpr_data0(gpr_data0), .gpr_data1(gpr_data1),
      .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_result(ex_result),
      .mem_rd(mem_rd), .mem_we(mem_we), .mem_result(mem_result),
      .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op0(out_op0), .out_op1(out_op1),
      .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference pipeline register
   logic        m_valid = 1'b0;
   logic        m_known = 1'b0;
   logic [31:0] m_op0 = '0, m_op1 = '0;
   logic [4:0]  m_rd = '0;
   logic        m_rd_we = 1'b0, m_is_load = 1'b0;
   logic        last_ir;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] resolve(input logic use_s, input logic [4:0] rs, input logic [31:0] gpr);
      logic [4:0]  rd  [3];
      logic        we  [3];
      logic [31:0] val [3];
      rd[0] = ex_rd;  we[0] = ex_we && !ex_is_load; val[0] = ex_result;
      rd[1] = mem_rd; we[1] = mem_we;               val[1] = mem_result;
      rd[2] = wb_rd;  we[2] = wb_we;                val[2] = wb_data;
      if (rs == 5'd0) return 32'd0;
      for (int k = 0; k < 3; k++)
         if (use_s && we[k] && rd[k] == rs) return val[k];
      return gpr;
   endfunction

   task automatic step();
      logic        hz, adv, ir;
      logic [31:0] n0, n1;
      #1;
      hz  = in_valid && ex_is_load && ex_we &&
            ((in_use0 && ex_rd == in_rs0 && in_rs0 != 5'd0) ||
             (in_use1 && ex_rd == in_rs1 && in_rs1 != 5'd0));
      adv = !m_valid || out_ready;
      ir  = adv && !hz && !flush;
      last_ir = in_ready;
      check("in_ready", 32'(in_ready), 32'(ir));
      check("gpr_addr0", 32'(gpr_addr0), 32'(in_rs0));
      check("gpr_addr1", 32'(gpr_addr1), 32'(in_rs1));
      n0 = resolve(in_use0, in_rs0, gpr_data0);
      n1 = resolve(in_use1, in_rs1, gpr_data1);
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0; m_known = 1'b1;
         m_op0 = '0; m_op1 = '0; m_rd = '0; m_rd_we = 1'b0; m_is_load = 1'b0;
      end else if (flush) begin
         m_valid = 1'b0;
      end else if (adv) begin
         m_valid = in_valid && !hz; m_known = m_valid;
         m_op0 = n0; m_op1 = n1; m_rd = in_rd; m_rd_we = in_rd_we; m_is_load = in_is_load;
      end
      #1;
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_known) begin
         check("out_op0", out_op0, m_op0);
         check("out_op1", out_op1, m_op1);
         check("out_rd", 32'(out_rd), 32'(m_rd));
         check("out_rd_we", 32'(out_rd_we), 32'(m_rd_we));
         check("out_is_load", 32'(out_is_load), 32'(m_is_load));
      end
   endtask

   task automatic clear_fwd();
      ex_we = 0; ex_is_load = 0; mem_we = 0; wb_we = 0;
      ex_rd = 0; mem_rd = 0; wb_rd = 0;
      ex_result = 0; mem_result = 0; wb_data = 0;
   endtask

   initial begin
      rst = 1; flush = 0; in_valid = 0; out_ready = 1;
      in_rs0 = 0; in_rs1 = 0; in_use0 = 0; in_use1 = 0;
      in_rd = 0; in_rd_we = 0; in_is_load = 0;
      gpr_data0 = 0; gpr_data1 = 0;
      clear_fwd();
      step();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_op0", out_op0, 32'd0);
      rst = 0;

      // independent operands
      in_valid = 1; in_rs0 = 3; in_rs1 = 4; in_use0 = 1; in_use1 = 1;
      in_rd = 9; in_rd_we = 1; gpr_data0 = 32'h11; gpr_data1 = 32'h22;
      step();
      check("nodep_op0", out_op0, 32'h11);
      check("nodep_op1", out_op1, 32'h22);
      check("nodep_valid", 32'(out_valid), 32'd1);

      // priority EX > MEM > WB
      in_rs0 = 5; ex_rd = 5; mem_rd = 5; wb_rd = 5;
      ex_we = 1; mem_we = 1; wb_we = 1;
      ex_result = 32'hA; mem_result = 32'hB; wb_data = 32'hC;
      step(); check("prio_ex", out_op0, 32'hA);
      ex_we = 0;
      step(); check("prio_mem", out_op0, 32'hB);
      mem_we = 0;
      step(); check("prio_wb", out_op0, 32'hC);

      // $0 always reads zero
      in_rs0 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
      ex_we = 1; mem_we = 1; wb_we = 1; gpr_data0 = 32'hFFFF_FFFF;
      ex_result = 32'hFFFF_FFFF; mem_result = 32'hFFFF_FFFF; wb_data = 32'hFFFF_FFFF;
      step(); check("zero_reg", out_op0, 32'd0);

      // load-use: one bubble then MEM forwarding
      clear_fwd();
      in_rs0 = 3; in_rs1 = 7; ex_rd = 7; ex_we = 1; ex_is_load = 1;
      step();
      check("lu_stall_ready", 32'(last_ir), 32'd0);
      check("lu_bubble", 32'(out_valid), 32'd0);
      clear_fwd();
      mem_rd = 7; mem_we = 1; mem_result = 32'h1234;
      step();
      check("lu_ready", 32'(last_ir), 32'd1);
      check("lu_op1", out_op1, 32'h1234);
      check("lu_valid", 32'(out_valid), 32'd1);
      clear_fwd();
      in_use1 = 0; ex_rd = 7; ex_we = 1; ex_is_load = 1;
      step();
      check("lu_nouse_ready", 32'(last_ir), 32'd1);
      check("lu_nouse_valid", 32'(out_valid), 32'd1);

      // backpressure holds captured operands
      clear_fwd(); in_use1 = 1;
      in_rs0 = 3; gpr_data0 = 32'h55;
      step(); check("bp_capture", out_op0, 32'h55);
      out_ready = 0; wb_rd = 3; wb_we = 1; wb_data = 32'h99; gpr_data0 = 32'h66;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_ready", 32'(last_ir), 32'd0);
         check("bp_op0", out_op0, 32'h55);
         check("bp_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1;

      // flush during a load-use stall drops the instruction
      clear_fwd();
      in_rs1 = 7; ex_rd = 7; ex_we = 1; ex_is_load = 1; flush = 1;
      step(); check("flush_valid", 32'(out_valid), 32'd0);
      flush = 0; in_valid = 0; clear_fwd();
      step(); check("flush_dropped", 32'(out_valid), 32'd0);

      // reset mid-operation
      in_valid = 1; gpr_data0 = 32'h77;
      step(); check("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1;
      step();
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_op0", out_op0, 32'd0);
      check("rst_mid_rd_we", 32'(out_rd_we), 32'd0);
      rst = 0;

      // randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(0, 49) == 0);
         flush      = ($urandom_range(0, 11) == 0);
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 9) < 7);
         in_rs0     = 5'($urandom_range(0, 3));
         in_rs1     = 5'($urandom_range(0, 3));
         in_use0    = 1'($urandom);
         in_use1    = 1'($urandom);
         in_rd      = 5'($urandom);
         in_rd_we   = 1'($urandom);
         in_is_load = 1'($urandom);
         gpr_data0  = $urandom;
         gpr_data1  = $urandom;
         ex_rd      = 5'($urandom_range(0, 3));
         mem_rd     = 5'($urandom_range(0, 3));
         wb_rd      = 5'($urandom_range(0, 3));
         ex_we      = 1'($urandom);
         ex_is_load = ($urandom_range(0, 3) == 0);
         mem_we     = 1'($urandom);
         wb_we      = 1'($urandom);
         ex_result  = $urandom;
         mem_result = $urandom;
         wb_data    = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
